// File: rtl/vc_req_to_port_req.sv
// Folds per-VC allocator grants into per-port switch-allocator requests, all registered.
// Optional VC_GRANT_ONEHOT_CHECK_EN adds grant_err flagging multi-hot grant rows.
module vc_req_to_port_req #(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned NUM_VC    = 2,
  localparam int unsigned V        = NUM_PORTS * NUM_VC,
  localparam int unsigned PW       = $clog2(NUM_PORTS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [V-1:0][V-1:0]          vc_grants,
  output logic [NUM_PORTS-1:0]         port_req [NUM_PORTS-1:0],
  output logic [V-1:0]                 vc_req_valid,
  output logic [V-1:0][PW-1:0]         vc_out_port
`ifdef VC_GRANT_ONEHOT_CHECK_EN
  ,
  output logic [V-1:0]                 grant_err
`endif
);

  logic [NUM_PORTS-1:0] port_req_d [NUM_PORTS-1:0];
  logic [V-1:0]         vc_req_valid_d;
  logic [V-1:0][PW-1:0] vc_out_port_d;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_req_d[p] = '0;
    end
    vc_req_valid_d = '0;
    vc_out_port_d  = '0;
    for (int v = 0; v < V; v++) begin
      vc_req_valid_d[v] = |vc_grants[v];
      // Scan downwards so the lowest set grant bit is the last one written.
      for (int o = V - 1; o >= 0; o--) begin
        if (vc_grants[v][o]) begin
          vc_out_port_d[v] = PW'(unsigned'(o) / NUM_VC);
        end
      end
      for (int o = 0; o < V; o++) begin
        if (vc_grants[v][o]) begin
          port_req_d[unsigned'(v) / NUM_VC][unsigned'(o) / NUM_VC] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        port_req[p] <= '0;
      end
      vc_req_valid <= '0;
      vc_out_port  <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        port_req[p] <= port_req_d[p];
      end
      vc_req_valid <= vc_req_valid_d;
      vc_out_port  <= vc_out_port_d;
    end
  end

`ifdef VC_GRANT_ONEHOT_CHECK_EN
  logic [V-1:0] grant_err_d;

  always_comb begin
    grant_err_d = '0;
    for (int v = 0; v < V; v++) begin
      // x & (x-1) clears the lowest set bit; anything left means multi-hot.
      grant_err_d[v] = |(vc_grants[v] & (vc_grants[v] - V'(1)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_err <= '0;
    end else begin
      grant_err <= grant_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_vc_req_to_port_req.sv
// Directed + random bench for vc_req_to_port_req (NUM_PORTS=2, NUM_VC=2) with an
// expected-result queue; honours VC_GRANT_ONEHOT_CHECK_EN when defined.
module tb_vc_req_to_port_req;

  localparam int unsigned NP = 2;
  localparam int unsigned NC = 2;
  localparam int unsigned V  = NP * NC;
  localparam int unsigned PW = $clog2(NP);
  localparam int unsigned GW = V * V;

  typedef struct packed {
    logic [NP*NP-1:0] pr;
    logic [V-1:0]     valid;
    logic [V*PW-1:0]  op;
    logic [V-1:0]     err;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic [V-1:0][V-1:0] vc_grants;
  logic [NP-1:0]       port_req [NP-1:0];
  logic [V-1:0]        vc_req_valid;
  logic [V-1:0][PW-1:0] vc_out_port;
`ifdef VC_GRANT_ONEHOT_CHECK_EN
  logic [V-1:0]        grant_err;
`endif

  vc_req_to_port_req #(
    .NUM_PORTS (NP),
    .NUM_VC    (NC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vc_grants    (vc_grants),
    .port_req     (port_req),
    .vc_req_valid (vc_req_valid),
    .vc_out_port  (vc_out_port)
`ifdef VC_GRANT_ONEHOT_CHECK_EN
    ,
    .grant_err    (grant_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb [$];
  exp_t last_exp;
  exp_t obs;

  always_comb begin
    obs = '0;
    for (int p = 0; p < NP; p++) begin
      for (int q = 0; q < NP; q++) begin
        obs.pr[p*NP+q] = port_req[p][q];
      end
    end
    obs.valid = vc_req_valid;
    for (int v = 0; v < V; v++) begin
      obs.op[v*PW +: PW] = vc_out_port[v];
    end
`ifdef VC_GRANT_ONEHOT_CHECK_EN
    obs.err = grant_err;
`endif
  end

  // Independent reference: per-port-pair OR, ascending first-hit search, popcount.
  function automatic exp_t model(input logic [V-1:0][V-1:0] g);
    exp_t e;
    bit   found;
    bit   acc;
    e = '0;
    for (int p = 0; p < NP; p++) begin
      for (int q = 0; q < NP; q++) begin
        acc = 1'b0;
        for (int k = 0; k < NC; k++) begin
          for (int m = 0; m < NC; m++) begin
            acc = acc | g[p*NC+k][q*NC+m];
          end
        end
        e.pr[p*NP+q] = acc;
      end
    end
    for (int v = 0; v < V; v++) begin
      e.valid[v] = (g[v] != '0);
      found = 1'b0;
      for (int o = 0; o < V; o++) begin
        if (!found && g[v][o]) begin
          e.op[v*PW +: PW] = PW'(o / NC);
          found = 1'b1;
        end
      end
      e.err[v] = ($countones(g[v]) > 1);
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".port_req"}, 32'(obs.pr), 32'(e.pr));
    check({tag, ".vc_req_valid"}, 32'(obs.valid), 32'(e.valid));
    check({tag, ".vc_out_port"}, 32'(obs.op), 32'(e.op));
`ifdef VC_GRANT_ONEHOT_CHECK_EN
    check({tag, ".grant_err"}, 32'(obs.err), 32'(e.err));
`endif
  endtask

  // Drive at negedge, confirm outputs still hold the old result, then check after the edge.
  task automatic step(input string tag, input logic [V-1:0][V-1:0] g, input exp_t e);
    exp_t got;
    @(negedge clk);
    vc_grants = g;
    sb.push_back(e);
    #1;
    check_all({tag, ".hold"}, last_exp);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check_all(tag, got);
    last_exp = got;
  endtask

  logic [V-1:0][V-1:0] g;
  exp_t                 zero_e;

  initial begin
    zero_e    = '0;
    rst_n     = 1'b0;
    vc_grants = {4'h8, 4'h2, 4'h4, 4'h1};
    #1;
    check_all("reset_initial", zero_e);
    @(posedge clk);
    #1;
    check_all("reset_edge", zero_e);
    @(negedge clk);
    vc_grants = '0;
    rst_n     = 1'b1;
    last_exp  = zero_e;

    // Rows {1,4,2,8}: every port reaches both outputs.
    step("rows_1_4_2_8", {4'h8, 4'h2, 4'h4, 4'h1},
         '{pr: 4'b1111, valid: 4'b1111, op: 4'b1010, err: 4'b0000});
    // Rows {1,2,0,0}: two VCs of port 0 to output 0 merge into one bit.
    step("rows_1_2_0_0", {4'h0, 4'h0, 4'h2, 4'h1},
         '{pr: 4'b0001, valid: 4'b0011, op: 4'b0000, err: 4'b0000});
    // Multi-hot row 2: lowest bit picks port 1.
    step("row2_multihot", {4'h0, 4'hC, 4'h0, 4'h0},
         '{pr: 4'b1000, valid: 4'b0100, op: 4'b0100, err: 4'b0100});
    step("all_zero", '0, zero_e);
    // Row 3 = 4'b0110 spans both ports; lowest bit (o=1) -> port 0.
    step("row3_span", {4'h6, 4'h0, 4'h0, 4'h0},
         '{pr: 4'b1100, valid: 4'b1000, op: 4'b0000, err: 4'b1000});

    for (int i = 0; i < 12; i++) begin
      g = GW'($urandom);
      step($sformatf("rand%0d", i), g, model(g));
    end

    // Asynchronous reset between edges, then reload on first edge after release.
    step("pre_reset", {4'h8, 4'h2, 4'h4, 4'h1}, model({4'h8, 4'h2, 4'h4, 4'h1}));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("rst_async", zero_e);
    @(negedge clk);
    g         = {4'h1, 4'h3, 4'h8, 4'h4};
    vc_grants = g;
    @(posedge clk);
    #1;
    check_all("rst_held", zero_e);
    #2;
    rst_n = 1'b1;
    sb.push_back(model(g));
    @(posedge clk);
    #1;
    last_exp = sb.pop_front();
    check_all("rst_reload", last_exp);

    step("post_reset_zero", '0, zero_e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
